// File: rtl/radio_pwm_out.sv
// RC-style PWM transmitter: one frame of PERIOD_US clk_1M cycles, high for MIN_US + cmd_active cycles.
// Optional command-loss failsafe is compiled in with `define RADIO_PWM_FAILSAFE_EN.
module radio_pwm_out #(
    parameter int MIN_US    = 987,
    parameter int PERIOD_US = 20000
`ifdef RADIO_PWM_FAILSAFE_EN
    ,
    parameter int         FAILSAFE_FRAMES = 25,
    parameter logic [9:0] FAILSAFE_CMD    = 10'd0
`endif
) (
    input  logic       clk_1M,
    input  logic       rst,
    input  logic       enable,
    input  logic [9:0] cmd,
    input  logic       cmd_valid,
    output logic       pwm,
    output logic       frame_start,
    output logic [9:0] cmd_active,
    output logic       failsafe
);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    localparam logic [14:0] LAST_CTR = 15'(PERIOD_US - 1);
    localparam logic [10:0] MIN_W    = 11'(MIN_US);

    state_t      state;
    logic [14:0] ctr;
    logic [9:0]  pending;
    logic [9:0]  load_value;
    logic [10:0] width;
    logic [14:0] high_last;
    logic        boundary;

    // Pulse width never exceeds 2010 for the legal cmd range, so 11 bits cannot wrap.
    assign width     = MIN_W + {1'b0, cmd_active};
    assign high_last = {4'b0, width} - 15'd1;
    assign boundary  = enable && ((state == IDLE) || (state == LOW && ctr == LAST_CTR));

`ifdef RADIO_PWM_FAILSAFE_EN
    localparam int                MISS_W   = $clog2(FAILSAFE_FRAMES + 1);
    localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(FAILSAFE_FRAMES);

    logic [MISS_W-1:0] miss;
    logic [MISS_W-1:0] miss_next;
    logic              wrote;
    logic              fs_q;
    logic              fs_next;

    // NOTE: every variable driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        miss_next = miss;
        if (wrote) begin
            miss_next = '0;
        end else if (miss != MISS_MAX) begin
            miss_next = miss + MISS_W'(1);
        end
        fs_next    = fs_q | (miss_next == MISS_MAX);
        load_value = fs_next ? FAILSAFE_CMD : pending;
    end

    // A write on the boundary edge counts toward the next interval, mirroring the no-bypass load.
    always_ff @(posedge clk_1M or negedge rst) begin
        if (!rst) begin
            miss  <= '0;
            wrote <= 1'b0;
            fs_q  <= 1'b0;
        end else if (cmd_valid) begin
            miss  <= '0;
            wrote <= 1'b1;
            fs_q  <= 1'b0;
        end else if (boundary) begin
            miss  <= miss_next;
            wrote <= 1'b0;
            fs_q  <= fs_next;
        end
    end

    assign failsafe = fs_q;
`else
    assign load_value = pending;
    assign failsafe   = 1'b0;
`endif

    always_ff @(posedge clk_1M or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ctr         <= '0;
            pending     <= '0;
            cmd_active  <= '0;
            pwm         <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments sample pre-edge values, so a boundary load takes
            // pending from before a same-edge write; the new command lands one frame later.
            frame_start <= 1'b0;
            if (cmd_valid) begin
                pending <= cmd;
            end

            if (boundary) begin
                state       <= HIGH;
                ctr         <= '0;
                pwm         <= 1'b1;
                frame_start <= 1'b1;
                cmd_active  <= load_value;
            end else begin
                case (state)
                    IDLE: begin
                        pwm <= 1'b0;
                        ctr <= '0;
                    end
                    HIGH: begin
                        ctr <= ctr + 15'd1;
                        if (ctr == high_last) begin
                            pwm   <= 1'b0;
                            state <= LOW;
                        end
                    end
                    LOW: begin
                        if (ctr == LAST_CTR) begin
                            state <= IDLE;
                            ctr   <= '0;
                        end else begin
                            ctr <= ctr + 15'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        pwm   <= 1'b0;
                        ctr   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_radio_pwm_out.sv
// Self-checking bench for radio_pwm_out: directed test-plan steps plus a random phase,
// checked against a frame-level model of pulse timing and command shadowing.
`timescale 1ns / 1ps
module tb_radio_pwm_out;

    localparam int MIN_US    = 987;
    localparam int PERIOD_US = 2048;
`ifdef RADIO_PWM_FAILSAFE_EN
    localparam int         FS_FRAMES = 4;
    localparam logic [9:0] FS_CMD    = 10'd0;
`endif

    logic       clk_1M = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic [9:0] cmd = '0;
    logic       cmd_valid = 1'b0;
    logic       pwm;
    logic       frame_start;
    logic [9:0] cmd_active;
    logic       failsafe;

    int checks = 0;
    int errors = 0;

    // Model: frame position, command shadowing and failsafe bookkeeping in plain arithmetic.
    bit m_run = 1'b0;
    int m_pos = 0;
    int m_active = 0;
    int m_pending = 0;
    bit m_fs = 1'b0;
`ifdef RADIO_PWM_FAILSAFE_EN
    int m_miss = 0;
    bit m_wrote = 1'b0;
`endif

    int hi_cnt = 0;
    int len_cnt = 0;
    int mis = 0;
    int last_hi = 0;
    int last_len = 0;

    always #500 clk_1M = ~clk_1M;

    radio_pwm_out #(
        .MIN_US         (MIN_US),
        .PERIOD_US      (PERIOD_US)
`ifdef RADIO_PWM_FAILSAFE_EN
        ,
        .FAILSAFE_FRAMES(FS_FRAMES),
        .FAILSAFE_CMD   (FS_CMD)
`endif
    ) dut (
        .clk_1M     (clk_1M),
        .rst        (rst),
        .enable     (enable),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .pwm        (pwm),
        .frame_start(frame_start),
        .cmd_active (cmd_active),
        .failsafe   (failsafe)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance the model across the next rising edge using the inputs now being driven.
    task automatic adv();
        bit bnd;
        bnd = 1'b0;
        if (!m_run) begin
            bnd = enable;
        end else if (m_pos == PERIOD_US - 1) begin
            bnd = enable;
            if (!enable) m_run = 1'b0;
        end else begin
            m_pos++;
        end
        if (bnd) begin
            m_run = 1'b1;
            m_pos = 0;
`ifdef RADIO_PWM_FAILSAFE_EN
            if (!m_wrote) m_miss++;
            if (m_miss >= FS_FRAMES) m_fs = 1'b1;
            m_active = m_fs ? int'(FS_CMD) : m_pending;
            m_wrote  = 1'b0;
`else
            m_active = m_pending;
`endif
        end
        if (cmd_valid) begin
            m_pending = int'(cmd);
`ifdef RADIO_PWM_FAILSAFE_EN
            m_miss  = 0;
            m_fs    = 1'b0;
            m_wrote = 1'b1;
`endif
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_pos = 0;
        m_active = 0;
        m_pending = 0;
        m_fs = 1'b0;
`ifdef RADIO_PWM_FAILSAFE_EN
        m_miss = 0;
        m_wrote = 1'b0;
`endif
        hi_cnt = 0;
        len_cnt = 0;
        mis = 0;
    endtask

    task automatic observe();
        bit exp_fs;
        bit exp_pwm;
        exp_fs  = m_run && (m_pos == 0);
        exp_pwm = m_run && (m_pos < MIN_US + m_active);
        if (frame_start === 1'b1 || exp_fs) chk("frame_start", 32'(frame_start), 32'(exp_fs));
        if (exp_fs) begin
            chk("cmd_active", 32'(cmd_active), m_active);
            chk("failsafe", 32'(failsafe), 32'(m_fs));
        end
        if (frame_start === 1'b1) begin
            hi_cnt  = 0;
            len_cnt = 0;
        end
        len_cnt++;
        if (pwm === 1'b1) hi_cnt++;
        if (pwm !== exp_pwm) mis++;
        if (m_run && m_pos == PERIOD_US - 1) begin
            last_hi  = hi_cnt;
            last_len = len_cnt;
            chk("pulse_width", hi_cnt, MIN_US + m_active);
            chk("frame_len", len_cnt, PERIOD_US);
            chk("pwm_shape", mis, 0);
            mis = 0;
        end
    endtask

    // Called at a falling edge: drive inputs for the next rising edge, then sample after it.
    task automatic cycle(input bit wr, input logic [9:0] val);
        cmd_valid = wr;
        cmd = wr ? val : 10'($urandom);
        adv();
        @(negedge clk_1M);
        observe();
    endtask

    task automatic run(input int n);
        repeat (n) cycle(1'b0, 10'd0);
    endtask

    task automatic wait_pos(input int p);
        int n;
        bit reached;
        n = 0;
        do begin
            cycle(1'b0, 10'd0);
            n++;
            reached = m_run && (m_pos == p);
        end while (!reached && n < 3 * PERIOD_US);
        if (!reached) chk("wait_pos", m_pos, p);
    endtask

    initial begin
        repeat (3) @(negedge clk_1M);
        chk("rst_pwm", 32'(pwm), 0);
        chk("rst_frame_start", 32'(frame_start), 0);
        chk("rst_cmd_active", 32'(cmd_active), 0);
        chk("rst_failsafe", 32'(failsafe), 0);
        rst = 1'b1;
        run(5);
        chk("idle_shape", mis, 0);

        // cmd=0 then enable: first boundary on the next edge, 987-cycle pulse
        enable = 1'b1;
        cycle(1'b1, 10'd0);
        chk("first_fs", 32'(frame_start), 1);
        wait_pos(PERIOD_US - 1);
        chk("pulse_cmd0", last_hi, 987);

        // mid-frame write of 1023 only affects the following frame
        wait_pos(500);
        cycle(1'b1, 10'd1023);
        wait_pos(PERIOD_US - 1);
        chk("pulse_unchanged", last_hi, 987);
        wait_pos(PERIOD_US - 1);
        chk("pulse_1023", last_hi, 2010);

        // write on the frame_start cycle
        cycle(1'b0, 10'd0);
        cycle(1'b1, 10'd512);
        wait_pos(PERIOD_US - 1);
        chk("pulse_old_at_fs", last_hi, 2010);
        wait_pos(PERIOD_US - 1);
        chk("pulse_512", last_hi, 1499);

        // write sampled on the boundary edge itself: no bypass
        cycle(1'b1, 10'd77);
        wait_pos(PERIOD_US - 1);
        chk("pulse_nobypass", last_hi, 1499);
        wait_pos(PERIOD_US - 1);
        chk("pulse_77", last_hi, 1064);

        // two writes in one frame: last one wins
        wait_pos(400);
        cycle(1'b1, 10'd100);
        wait_pos(900);
        cycle(1'b1, 10'd200);
        wait_pos(PERIOD_US - 1);
        chk("pulse_before_200", last_hi, 1064);
        wait_pos(600);
        cycle(1'b1, 10'd300);
        wait_pos(PERIOD_US - 1);
        chk("pulse_last_wins", last_hi, 1187);

        // enable dropped mid-pulse: full pulse, full frame, then idle
        wait_pos(100);
        enable = 1'b0;
        wait_pos(PERIOD_US - 1);
        chk("pulse_after_disable", last_hi, 1287);
        chk("len_after_disable", last_len, PERIOD_US);
        run(300);
        chk("idle_after_disable", mis, 0);
        chk("idle_pwm", 32'(pwm), 0);

        enable = 1'b1;
        cycle(1'b0, 10'd0);
        chk("restart_fs", 32'(frame_start), 1);

        // async reset mid-pulse
        wait_pos(200);
        rst = 1'b0;
        #1;
        chk("rst_mid_pwm", 32'(pwm), 0);
        chk("rst_mid_cmd_active", 32'(cmd_active), 0);
        model_reset();
        @(negedge clk_1M);
        rst = 1'b1;
        cycle(1'b0, 10'd0);
        chk("post_reset_fs", 32'(frame_start), 1);
        wait_pos(PERIOD_US - 1);
        chk("pulse_after_reset", last_hi, 987);

        // random writes and enable toggling
        for (int i = 0; i < 4 * PERIOD_US; i++) begin
            if (i % 512 == 0) enable = ($urandom_range(0, 3) != 0);
            cycle($urandom_range(0, 599) == 0, 10'($urandom));
        end

        // command loss: failsafe engages (when built in), then a write clears it
        enable = 1'b1;
        wait_pos(100);
        cycle(1'b1, 10'd700);
        run(6 * PERIOD_US);
`ifdef RADIO_PWM_FAILSAFE_EN
        chk("failsafe_engaged", 32'(failsafe), 1);
        wait_pos(PERIOD_US - 1);
        chk("pulse_failsafe", last_hi, 987);
`else
        chk("failsafe_tied", 32'(failsafe), 0);
        wait_pos(PERIOD_US - 1);
        chk("pulse_held", last_hi, 1687);
`endif
        wait_pos(50);
        cycle(1'b1, 10'd400);
        chk("failsafe_clear", 32'(failsafe), 0);
        wait_pos(PERIOD_US - 1);
        wait_pos(PERIOD_US - 1);
        chk("pulse_400", last_hi, 1387);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/radio_pwm_out.md
Name: radio_pwm_out

Overview:
- Generates an RC-style PWM pulse train (servo/ESC/receiver-emulation) from a 10-bit command.
- It is the transmit-side counterpart of the PWM radio decoder. Pulse width is MIN_US + cmd microseconds, so 987..2010 us maps to cmd 0..1023.
- Runs from the 1 MHz tick clock. One instance drives each output channel.

Parameters:
- MIN_US, 987: high-time in clk_1M cycles for cmd=0.
- PERIOD_US, 20000: frame length in clk_1M cycles. Must be >= MIN_US+1023+2.
- FAILSAFE_FRAMES, 25: frames without a command write before failsafe engages. Used only with RADIO_PWM_FAILSAFE_EN.
- FAILSAFE_CMD, 0: command applied on failsafe. Used only with RADIO_PWM_FAILSAFE_EN.

Ports:
- clk_1M  in  1  1 MHz clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  run request; sampled only at frame boundaries.
- cmd  in  10  new command value.
- cmd_valid  in  1  one-cycle write strobe for cmd.
- pwm  out  1  registered PWM output.
- frame_start  out  1  one-cycle pulse on the first high cycle of each frame.
- cmd_active  out  10  command used by the current frame.
- failsafe  out  1  failsafe engaged flag.

Behaviour:
- Reset (rst=0, async): pwm=0, frame_start=0, cmd_active=0, failsafe=0, pending=0, frame counter ctr=0, state=IDLE, miss counter=0.
- Registers:
  - pending (10b): loaded from cmd on every cycle with cmd_valid=1; the last write wins.
  - cmd_active (10b): shadow register, loaded from pending only at a frame boundary, so a frame never glitches mid-pulse.
- Counter: ctr is 15-bit (sized for PERIOD_US), counts 0..PERIOD_US-1, then wraps.
- State IDLE:
  - pwm=0, ctr held at 0.
  - enable=1 -> next cycle enters HIGH (the frame boundary).
- State HIGH:
  - pwm=1 exactly MIN_US+cmd_active cycles, measured at the pwm pin.
  - Width arithmetic uses 11 bits (MIN_US + zero-extended cmd_active); no wrap.
  - After the last high cycle -> LOW.
- State LOW:
  - pwm=0 until ctr==PERIOD_US-1.
  - At that cycle: enable=1 -> HIGH with a new boundary; enable=0 -> IDLE.
- Frame boundary actions, visible on the first HIGH cycle:
  - ctr=0, frame_start=1, cmd_active<=pending, pwm=1.
- Frame length: exactly PERIOD_US cycles from one frame_start to the next.
- Simultaneous cmd_valid and boundary: the load uses pending before the write (no bypass). The new value applies from the next frame.
- enable deasserted mid-frame: the current frame completes unchanged, with a full pulse and full period. Pulses are never truncated.
- enable reasserted in IDLE: a new frame starts on the next cycle.
- Async reset mid-pulse: pwm drops to 0 immediately. After release with enable=1, the first frame starts within 2 cycles.
- Latency: cmd_valid to effect is at most PERIOD_US+1 cycles, i.e. the next boundary.
- cmd is not clamped; the full 0..1023 range is legal.

Optional Feature:
- Macro RADIO_PWM_FAILSAFE_EN.
- When defined:
  - A miss counter increments at each frame boundary with no cmd_valid since the previous boundary.
  - Any cmd_valid clears the miss counter and failsafe.
  - When the miss counter reaches FAILSAFE_FRAMES: failsafe=1 at that boundary, and that frame and all later frames load cmd_active<=FAILSAFE_CMD instead of pending.
  - The next cmd_valid clears failsafe. Normal loading from pending resumes at the following boundary.
- When undefined:
  - No miss counter; the last command is held indefinitely.
  - failsafe is tied to 0.

Test Plan:
- Reset, then cmd=0 write, enable=1 -> pwm high 987 cycles, low 19013; frame_start period 20000; cmd_active=0.
- Write cmd=1023 mid-frame -> current pulse width unchanged; next pulse 2010 cycles; cmd_active=1023 from the next frame_start.
- Write cmd=512 on the exact cycle frame_start asserts -> that frame uses the old value; the following frame is 1499 cycles high.
- Writes 100 then 200 within one frame -> next pulse 1187 cycles (last write wins).
- enable=0 during a HIGH pulse of cmd=300 -> pulse completes at 1287 cycles, frame completes at 20000, then pwm stays 0 and no further frame_start.
- RADIO_PWM_FAILSAFE_EN, cmd=700, then no writes -> failsafe=1 at the 25th boundary and pulses become 987 cycles. Write cmd=400 -> failsafe=0 immediately; next frame pulse is 1387 cycles.
